// File: rtl/audio_rec_ctrl.sv
// Record/playback sequencer for the PDM capture RAM: records decimated samples, plays them
// back at the sample rate with optional looping, and drives a 4-LED progress display.
`timescale 1ns/1ps
module audio_rec_ctrl #(
    parameter int unsigned ADDR_W = 17,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rec_req,
    input  logic              play_req,
    input  logic              stop_req,
    input  logic              loop_en,
    input  logic              smp_valid,
    input  logic [DATA_W-1:0] smp_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              out_active,
    output logic [1:0]        state,
    output logic [ADDR_W:0]   rec_len,
    output logic [3:0]        led
);

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRec  = 2'b01,
        StPlay = 2'b10
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]     rec_len_q, rec_len_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic                ram_we_q, ram_we_d;
    logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
    logic                rd_s1_q, rd_s1_d;
    logic                rd_s2_q, rd_s2_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;

    logic [ADDR_W:0]     wr_cnt;
    logic [ADDR_W:0]     rd_cnt;
    logic [1:0]          led_t;

    assign wr_cnt = {1'b0, wr_ptr_q} + 1'b1;
    assign rd_cnt = {1'b0, rd_ptr_q} + 1'b1;

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        rec_len_d   = rec_len_q;
        ram_addr_d  = ram_addr_q;
        ram_we_d    = 1'b0;
        ram_wdata_d = ram_wdata_q;
        rd_s1_d     = 1'b0;
        // Issued reads drain through the pipeline regardless of state.
        rd_s2_d     = rd_s1_q;
        out_valid_d = rd_s2_q;
        out_data_d  = rd_s2_q ? ram_rdata : out_data_q;

        unique case (state_q)
            StIdle: begin
                if (stop_req) begin
                    state_d = StIdle;
                end else if (rec_req) begin
                    state_d   = StRec;
                    wr_ptr_d  = '0;
                    rec_len_d = '0;
                end else if (play_req && (rec_len_q != '0)) begin
                    state_d  = StPlay;
                    rd_ptr_d = '0;
                end
            end
            StRec: begin
                if (smp_valid) begin
                    ram_we_d    = 1'b1;
                    ram_addr_d  = wr_ptr_q;
                    ram_wdata_d = smp_data;
                    if (&wr_ptr_q) begin
                        rec_len_d = wr_cnt;
                        state_d   = StIdle;
                    end else begin
                        wr_ptr_d = wr_ptr_q + 1'b1;
                    end
                end
                // A coincident sample is written and counted before the stop takes effect.
                if (stop_req) begin
                    rec_len_d = smp_valid ? wr_cnt : {1'b0, wr_ptr_q};
                    state_d   = StIdle;
                end
            end
            StPlay: begin
                if (stop_req) begin
                    state_d = StIdle;
                end else if (smp_valid) begin
                    rd_s1_d    = 1'b1;
                    ram_addr_d = rd_ptr_q;
                    if (rd_cnt == rec_len_q) begin
                        rd_ptr_d = '0;
                        if (!loop_en) begin
                            state_d = StIdle;
                        end
                    end else begin
                        rd_ptr_d = rd_ptr_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            rec_len_q   <= '0;
            ram_addr_q  <= '0;
            ram_we_q    <= 1'b0;
            ram_wdata_q <= '0;
            rd_s1_q     <= 1'b0;
            rd_s2_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            rec_len_q   <= rec_len_d;
            ram_addr_q  <= ram_addr_d;
            ram_we_q    <= ram_we_d;
            ram_wdata_q <= ram_wdata_d;
            rd_s1_q     <= rd_s1_d;
            rd_s2_q     <= rd_s2_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    // Progress bar: REC fills from the bottom, PLAY empties from the bottom.
    assign led_t = (state_q == StRec) ? wr_ptr_q[ADDR_W-1 -: 2] : rd_ptr_q[ADDR_W-1 -: 2];

    always_comb begin
        led = 4'b0000;
        unique case (state_q)
            StRec:   led = 4'b1111 >> (2'd3 - led_t);
            StPlay:  led = 4'b1111 << led_t;
            StIdle:  led = (rec_len_q != '0) ? 4'b1111 : 4'b0000;
            default: led = 4'b0000;
        endcase
    end

    assign ram_addr   = ram_addr_q;
    assign ram_we     = ram_we_q;
    assign ram_wdata  = ram_wdata_q;
    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign out_active = (state_q == StPlay);
    assign state      = state_q;
    assign rec_len    = rec_len_q;

endmodule

// File: tb/tb_audio_rec_ctrl.sv
// Bench for audio_rec_ctrl (ADDR_W=4): directed scenarios plus random commands/strobes,
// checked every cycle against a sample-level model of the recorder.
`timescale 1ns/1ps
module tb_audio_rec_ctrl;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int N  = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          rec_req, play_req, stop_req, loop_en, smp_valid;
    logic [DW-1:0] smp_data;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_active;
    logic [1:0]    state;
    logic [AW:0]   rec_len;
    logic [3:0]    led;

    audio_rec_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .rec_req    (rec_req),
        .play_req   (play_req),
        .stop_req   (stop_req),
        .loop_en    (loop_en),
        .smp_valid  (smp_valid),
        .smp_data   (smp_data),
        .ram_addr   (ram_addr),
        .ram_we     (ram_we),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_active (out_active),
        .state      (state),
        .rec_len    (rec_len),
        .led        (led)
    );

    always #5 clk = ~clk;

    // Capture RAM with one-cycle registered read.
    logic [DW-1:0] mem [N];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } pend_t;

    int            checks = 0;
    int            failures = 0;
    int            edge_cnt = 0;
    int            m_mode = 0;
    int            m_wr = 0;
    int            m_len = 0;
    int            m_rd = 0;
    logic [DW-1:0] shadow [N];
    logic          exp_we = 1'b0;
    int            exp_addr = 0;
    logic [DW-1:0] exp_wdata = '0;
    pend_t         pq[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, obs, exp, edge_cnt);
        end
    endtask

    function automatic int exp_led();
        int t;
        if (m_mode == 1) begin
            t = m_wr / 4;
            return (1 << (t + 1)) - 1;
        end else if (m_mode == 2) begin
            t = m_rd / 4;
            return (15 << t) & 15;
        end
        return (m_len != 0) ? 15 : 0;
    endfunction

    // Effect of the inputs sampled at the coming clock edge.
    task automatic model_apply(input logic r, input logic p, input logic s, input logic v,
                               input logic [DW-1:0] d);
        int e;
        e = edge_cnt + 1;
        exp_we = 1'b0;
        case (m_mode)
            0: begin
                if (!s) begin
                    if (r) begin
                        m_mode = 1; m_wr = 0; m_len = 0;
                    end else if (p && m_len != 0) begin
                        m_mode = 2; m_rd = 0;
                    end
                end
            end
            1: begin
                if (v) begin
                    shadow[m_wr] = d;
                    exp_we = 1'b1; exp_addr = m_wr; exp_wdata = d;
                    m_wr++;
                    if (m_wr == N) begin
                        m_len = N; m_mode = 0;
                    end
                end
                if (s && m_mode == 1) begin
                    m_len = m_wr; m_mode = 0;
                end
            end
            default: begin
                if (s) begin
                    m_mode = 0;
                end else if (v) begin
                    exp_addr = m_rd;
                    pq.push_back('{due: e + 2, data: shadow[m_rd]});
                    m_rd++;
                    if (m_rd == m_len) begin
                        m_rd = 0;
                        if (!loop_en) m_mode = 0;
                    end
                end
            end
        endcase
    endtask

    task automatic check_all();
        check("state", 32'(state), 32'(m_mode));
        check("ram_we", 32'(ram_we), 32'(exp_we));
        check("ram_addr", 32'(ram_addr), 32'(exp_addr));
        if (exp_we) check("ram_wdata", 32'(ram_wdata), 32'(exp_wdata));
        check("rec_len", 32'(rec_len), 32'(m_len));
        check("led", 32'(led), 32'(exp_led()));
        check("out_active", 32'(out_active), 32'(m_mode == 2));
        if (pq.size() > 0 && pq[0].due == edge_cnt) begin
            check("out_valid", 32'(out_valid), 32'd1);
            check("out_data", 32'(out_data), 32'(pq[0].data));
            void'(pq.pop_front());
        end else begin
            check("out_valid", 32'(out_valid), 32'd0);
        end
    endtask

    task automatic step(input logic r, input logic p, input logic s, input logic v,
                        input logic [DW-1:0] d);
        rec_req = r; play_req = p; stop_req = s; smp_valid = v; smp_data = d;
        model_apply(r, p, s, v, d);
        @(posedge clk);
        edge_cnt++;
        @(negedge clk);
        check_all();
        rec_req = 1'b0; play_req = 1'b0; stop_req = 1'b0; smp_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic sample(input logic [DW-1:0] d);
        step(1'b0, 1'b0, 1'b0, 1'b1, d);
        idle(3);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        rec_req = 1'b0; play_req = 1'b0; stop_req = 1'b0; smp_valid = 1'b0;
        @(posedge clk);
        edge_cnt++;
        @(negedge clk);
        reset = 1'b0;
        m_mode = 0; m_wr = 0; m_rd = 0; m_len = 0;
        exp_we = 1'b0; exp_addr = 0;
        pq.delete();
        check_all();
    endtask

    initial begin
        reset = 1'b1; rec_req = 1'b0; play_req = 1'b0; stop_req = 1'b0;
        loop_en = 1'b0; smp_valid = 1'b0; smp_data = '0;
        @(negedge clk);
        do_reset();

        // Reset in the middle of a recording.
        step(1'b1, 1'b0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 5; i++) sample(8'(8'h20 + i));
        do_reset();

        // Full-buffer recording.
        step(1'b1, 1'b0, 1'b0, 1'b0, '0);
        for (int i = 0; i < N; i++) sample(8'(8'h10 + i));
        idle(2);
        for (int i = 0; i < N; i++) check("ram_content", 32'(mem[i]), 32'(8'h10 + i));

        // Stop coincident with the 7th sample.
        step(1'b1, 1'b0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 6; i++) sample(8'(8'h40 + i));
        step(1'b0, 1'b0, 1'b1, 1'b1, 8'h46);
        idle(2);
        check("stop_len", 32'(rec_len), 32'd7);
        check("stop_ram6", 32'(mem[6]), 32'h46);

        // One-shot playback; the 8th strobe must be ignored.
        loop_en = 1'b0;
        step(1'b0, 1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < 8; i++) sample('0);
        idle(4);

        // Looping playback of 3 samples, stopped with reads in flight.
        step(1'b1, 1'b0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 3; i++) sample(8'(8'h60 + i));
        step(1'b0, 1'b0, 1'b1, 1'b0, '0);
        loop_en = 1'b1;
        step(1'b0, 1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < 8; i++) sample('0);
        step(1'b0, 1'b0, 1'b0, 1'b1, '0);
        step(1'b0, 1'b0, 1'b0, 1'b1, '0);
        step(1'b0, 1'b0, 1'b1, 1'b1, '0);
        idle(5);
        loop_en = 1'b0;

        // Play with nothing recorded, then simultaneous rec+play.
        do_reset();
        step(1'b0, 1'b1, 1'b0, 1'b0, '0);
        check("play_empty", 32'(state), 32'd0);
        step(1'b1, 1'b1, 1'b0, 1'b0, '0);
        check("rec_over_play", 32'(state), 32'd1);
        step(1'b0, 1'b0, 1'b1, 1'b0, '0);

        // Random commands and strobes, including back-to-back strobes.
        for (int c = 0; c < 6000; c++) begin
            if ($urandom_range(0, 99) == 0) loop_en = ~loop_en;
            if ($urandom_range(0, 999) == 0) begin
                do_reset();
            end else begin
                step(($urandom_range(0, 39) == 0), ($urandom_range(0, 14) == 0),
                     ($urandom_range(0, 59) == 0), ($urandom_range(0, 2) == 0),
                     8'($urandom));
            end
        end
        idle(5);
        check("drain", 32'(pq.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
